exc_seq: RTL and testbench
==========================

# exc_seq

Exception/interrupt sequencer for the five-stage pipeline: sits beside the coprocessor-0 register block and decides, at the M stage, when an interrupt, a synchronous exception or an ERET is committed. It issues the single-cycle CP0 update strobe, flushes the pipeline and redirects the fetch PC to the handler or to EPC. It then holds off new entries until the refilled pipeline is clean. It also keeps a saturating count of taken exceptions for debug.

## Interface
- HANDLER_ADDR, 32'h0000_4180, handler entry address (bits [1:0] ignored)
- HOLD_CYCLES, 2, hold-off cycles after a redirect, legal range 1..15
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces every register to its reset value immediately
- m_valid  in  1  M stage holds a real instruction (0 = bubble)
- m_exccode  in  5  ExcCode[6:2] detected for the M instruction, 0 = none
- m_pc  in  30  PC[31:2] of the M instruction
- m_bd  in  1  M instruction is in a branch delay slot
- m_eret  in  1  M instruction is ERET
- irq  in  1  CP0 interrupt condition (HWInt & IM, IE, !EXL)
- exl  in  1  CP0 SR.EXL
- epc  in  30  CP0 EPC[31:2]
- stall_in  in  1  memory/bridge stall, pipeline frozen
- cp0_exc_we  out  1  one-cycle strobe: CP0 captures exccode/pc/bd and sets EXL
- cp0_exccode  out  5  ExcCode to CP0 (0 for interrupt)
- cp0_pc  out  30  PC[31:2] to CP0
- cp0_bd  out  1  delay-slot flag to CP0
- cp0_exl_clr  out  1  one-cycle strobe: CP0 clears EXL (ERET)
- flush  out  1  clear F/D/E/M pipeline registers
- pc_redirect  out  1  load redirect_pc into the PC
- redirect_pc  out  30  redirect target PC[31:2]
- busy  out  1  state != IDLE
- exc_count  out  16  taken exceptions+interrupts, saturating

## Operation
- All outputs are registered (Moore); state one-hot or encoded, implementer's choice.
- States: IDLE, ENTER, LEAVE, REDIR, HOLD.
- IDLE, sampled each edge; nothing happens while stall_in=1. Priority when stall_in=0 and m_valid=1:
  1. irq=1 → ENTER with cp0_exccode=0.
  2. m_exccode!=0 and exl=0 → ENTER with cp0_exccode=m_exccode.
  3. m_eret=1 → LEAVE.
  In ENTER, cp0_pc=m_pc and cp0_bd=m_bd are latched at the same edge. m_valid=0 blocks all three; the interrupt waits for the next real instruction. m_exccode!=0 with exl=1 is ignored (no nesting).
- ENTER, exactly 1 cycle: cp0_exc_we=1, flush=1; redirect_pc latched = HANDLER_ADDR[31:2]. Then REDIR. exc_count increments unless it is 16'hFFFF.
- LEAVE, exactly 1 cycle: cp0_exl_clr=1, flush=1; redirect_pc latched = epc. Then REDIR.
- REDIR: pc_redirect=1, held while stall_in=1; leaves at the first edge with stall_in=0. Then HOLD, with the counter loaded to HOLD_CYCLES-1.
- HOLD: all inputs ignored. Counter decrements each edge; leaves to IDLE at the edge where the counter is 0. HOLD lasts HOLD_CYCLES cycles.
- cp0_exccode, cp0_pc, cp0_bd and redirect_pc keep their last latched value outside ENTER/LEAVE.
- busy=1 in every state except IDLE.

## Timing
- Reset values: state IDLE, every strobe 0, flush 0, pc_redirect 0, cp0_exccode 0, cp0_pc 0, cp0_bd 0, redirect_pc 0, exc_count 0, busy 0, hold counter 0.
- A request sampled at edge k appears as follows:
  - ENTER/LEAVE strobes: cycle k→k+1.
  - pc_redirect: cycle k+1→k+2 (longer if stalled).
  - HOLD: cycles k+2..k+1+HOLD_CYCLES.
  - First new request is accepted at edge k+2+HOLD_CYCLES.
- Minimum turnaround with no stall is HOLD_CYCLES+2 cycles.
- Simultaneous irq, exception and ERET: irq wins. The instruction in M is flushed and re-executes after ERET. EPC comes from the CP0 bd handling.
- stall_in during ENTER/LEAVE does not stretch the strobes (1 cycle always); stretching applies only to REDIR.
- Reset asserted mid-sequence: outputs drop asynchronously; no partial strobe is ever repeated after reset deasserts.

## Test plan
- Reset in REDIR: assert reset with pc_redirect=1 → pc_redirect, flush and busy are 0 the same cycle; state is IDLE after release; exc_count=0.
- Exception: m_valid=1, m_exccode=5'd4, m_pc=30'h0C00, m_bd=0, exl=0 → next cycle cp0_exc_we=1, flush=1, cp0_exccode=4, cp0_pc=30'h0C00. The following cycle pc_redirect=1 with redirect_pc=30'h1060. busy=1 for 4 cycles; exc_count=1.
- Priority: irq=1, m_exccode=5'd10 and m_eret=1 together → cp0_exccode=0 and cp0_exl_clr stays 0.
- Bubble and nesting: irq=1 with m_valid=0 for 3 cycles → no action until m_valid=1. Then m_exccode=5'd12 with exl=1 → ignored, busy stays 0.
- ERET under stall: m_eret=1, epc=30'h0C01, stall_in=0 → cp0_exl_clr for 1 cycle. stall_in=1 for 3 cycles during REDIR → pc_redirect held 4 cycles with redirect_pc=30'h0C01, then HOLD for 2 cycles.
- Saturation: drive 65 537 exceptions → exc_count stops at 16'hFFFF.

Source files
------------

// File: rtl/exc_seq_if.sv
// exc_seq_if: signal bundle between the M-stage/CP0 side and the exception
// sequencer.
//   master : pipeline/CP0 side. Drives m_valid, m_exccode, m_pc, m_bd, m_eret,
//            irq, exl, epc and stall_in. Receives the CP0 update strobes, flush
//            and redirect controls, busy, exc_count and state_dbg.
//   slave  : exc_seq. Samples the inputs and drives the registered outputs.
// Handshake: there is no valid/ready pair on this bundle. m_valid qualifies
// the M-stage fields at each rising edge, and only in IDLE with stall_in=0.
// cp0_exc_we and cp0_exl_clr are single-cycle strobes that need no
// acknowledge. pc_redirect stays high until an edge samples stall_in=0.
interface exc_seq_if #(
  parameter int CNT_W = 16
);
  logic             m_valid;
  logic [4:0]       m_exccode;
  logic [29:0]      m_pc;
  logic             m_bd;
  logic             m_eret;
  logic             irq;
  logic             exl;
  logic [29:0]      epc;
  logic             stall_in;
  logic             cp0_exc_we;
  logic [4:0]       cp0_exccode;
  logic [29:0]      cp0_pc;
  logic             cp0_bd;
  logic             cp0_exl_clr;
  logic             flush;
  logic             pc_redirect;
  logic [29:0]      redirect_pc;
  logic             busy;
  logic [CNT_W-1:0] exc_count;
  logic [2:0]       state_dbg;

  modport master (
    output m_valid, m_exccode, m_pc, m_bd, m_eret, irq, exl, epc, stall_in,
    input  cp0_exc_we, cp0_exccode, cp0_pc, cp0_bd, cp0_exl_clr, flush,
           pc_redirect, redirect_pc, busy, exc_count, state_dbg
  );

  modport slave (
    input  m_valid, m_exccode, m_pc, m_bd, m_eret, irq, exl, epc, stall_in,
    output cp0_exc_we, cp0_exccode, cp0_pc, cp0_bd, cp0_exl_clr, flush,
           pc_redirect, redirect_pc, busy, exc_count, state_dbg
  );
endinterface

// File: rtl/exc_seq.sv
// exc_seq: exception/interrupt/ERET sequencer for the M stage.
// When an event is committed, the block pulses the CP0 update strobe
// (cp0_exc_we or cp0_exl_clr) and flush. It then drives pc_redirect, which
// stretches while stall_in is high. Finally it holds off new entries for
// HOLD_CYCLES cycles before it returns to IDLE.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : exc_seq_if.slave (M-stage inputs, CP0 strobes, redirect controls,
//           busy, saturating exc_count, state_dbg = encoded FSM state)
// All outputs are registered. They are computed from the next state, so each
// output is a flop that changes with the state register.
module exc_seq #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int          HOLD_CYCLES  = 2,
  parameter int          CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  exc_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTER = 3'd1,
    S_LEAVE = 3'd2,
    S_REDIR = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  localparam logic [3:0]       HOLD_LOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t     state, state_nx;
  logic [3:0] hold_cnt;
  logic       take_irq, take_exc, take_eret;
  logic       exc_ok;

  // Request decode: bubbles and stalls block everything. An interrupt beats
  // a synchronous exception, which beats ERET. Exceptions raised while EXL
  // is set are dropped, so handlers never nest.
  always_comb begin
    take_irq  = 1'b0;
    take_exc  = 1'b0;
    take_eret = 1'b0;
    exc_ok    = (bus.m_exccode != 5'd0) && !bus.exl;
    if (state == S_IDLE && !bus.stall_in && bus.m_valid) begin
      take_irq  = bus.irq;
      take_exc  = !bus.irq && exc_ok;
      take_eret = !bus.irq && !exc_ok && bus.m_eret;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (take_irq || take_exc) state_nx = S_ENTER;
        else if (take_eret)       state_nx = S_LEAVE;
      end
      S_ENTER: state_nx = S_REDIR;
      S_LEAVE: state_nx = S_REDIR;
      S_REDIR: if (!bus.stall_in) state_nx = S_HOLD;
      S_HOLD:  if (hold_cnt == 4'd0) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt        <= 4'd0;
      bus.cp0_exc_we  <= 1'b0;
      bus.cp0_exl_clr <= 1'b0;
      bus.flush       <= 1'b0;
      bus.pc_redirect <= 1'b0;
      bus.busy        <= 1'b0;
      bus.cp0_exccode <= 5'd0;
      bus.cp0_pc      <= 30'd0;
      bus.cp0_bd      <= 1'b0;
      bus.redirect_pc <= 30'd0;
      bus.exc_count   <= '0;
      bus.state_dbg   <= 3'd0;
    end else begin
      bus.cp0_exc_we  <= (state_nx == S_ENTER);
      bus.cp0_exl_clr <= (state_nx == S_LEAVE);
      bus.flush       <= (state_nx == S_ENTER) || (state_nx == S_LEAVE);
      bus.pc_redirect <= (state_nx == S_REDIR);
      bus.busy        <= (state_nx != S_IDLE);
      bus.state_dbg   <= state_nx;

      // Hold counter: load on REDIR exit, count down to 0 inside HOLD.
      if (state == S_REDIR && state_nx == S_HOLD) hold_cnt <= HOLD_LOAD;
      else if (state == S_HOLD && hold_cnt != 4'd0) hold_cnt <= hold_cnt - 4'd1;

      // The CP0 payload and the redirect target are captured with the
      // request. They then stay stable until the next accepted event.
      if (take_irq || take_exc) begin
        bus.cp0_exccode <= take_irq ? 5'd0 : bus.m_exccode;
        bus.cp0_pc      <= bus.m_pc;
        bus.cp0_bd      <= bus.m_bd;
        bus.redirect_pc <= HANDLER_ADDR[31:2];
        if (bus.exc_count != CNT_MAX) bus.exc_count <= bus.exc_count + 1'b1;
      end else if (take_eret) begin
        bus.redirect_pc <= bus.epc;
      end
    end
  end

endmodule

// File: tb/tb_exc_seq.sv
module tb_exc_seq;
  localparam int CNT_W = 6;
  localparam int EW    = 38;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   exp_cnt = 0;
  logic [EW-1:0] exp_q[$];
  logic prev_redir;

  exc_seq_if #(.CNT_W(CNT_W)) bus ();

  exc_seq #(.HANDLER_ADDR(32'h0000_4180), .HOLD_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] ev_exc(input logic [4:0] code, input logic [29:0] pc, input logic bd);
    return {2'd1, code, pc, bd};
  endfunction
  function automatic logic [EW-1:0] ev_eret();
    return {2'd2, 36'd0};
  endfunction
  function automatic logic [EW-1:0] ev_redir(input logic [29:0] pc);
    return {2'd3, 6'd0, pc};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      prev_redir = 1'b0;
    end else begin
      logic [EW-1:0] act;
      logic          seen;
      seen = 1'b0;
      act  = '0;
      if (bus.cp0_exc_we) begin
        act = ev_exc(bus.cp0_exccode, bus.cp0_pc, bus.cp0_bd); seen = 1'b1;
      end else if (bus.cp0_exl_clr) begin
        act = ev_eret(); seen = 1'b1;
      end else if (bus.pc_redirect && !prev_redir) begin
        act = ev_redir(bus.redirect_pc); seen = 1'b1;
      end
      prev_redir = bus.pc_redirect;
      if (seen) begin
        if (exp_q.size() == 0) check("unexpected_event", 64'(act), 64'd0);
        else check("event", 64'(act), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.m_valid   = 1'b0;
    bus.m_exccode = 5'd0;
    bus.m_eret    = 1'b0;
    bus.irq       = 1'b0;
    bus.m_bd      = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic irq, input logic [4:0] code, input logic [29:0] pc,
                       input logic bd, input logic eret);
    bus.m_valid   = 1'b1;
    bus.irq       = irq;
    bus.m_exccode = code;
    bus.m_pc      = pc;
    bus.m_bd      = bd;
    bus.m_eret    = eret;
    step();
    idle_inputs();
  endtask

  // Counts per-cycle activity until busy drops (sampled at negedges).
  task automatic watch(output int nb, output int nf, output int nr,
                       output int nx, output int ne);
    logic done;
    nb = 0; nf = 0; nr = 0; nx = 0; ne = 0; done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        done = 1'b1;
        break;
      end
      nb++;
      if (bus.flush)       nf++;
      if (bus.pc_redirect) nr++;
      if (bus.cp0_exc_we)  nx++;
      if (bus.cp0_exl_clr) ne++;
    end
    if (!done) check("watch_timeout", 64'(done), 64'd1);
  endtask

  task automatic bump_cnt();
    if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nb, nf, nr, nx, ne;
    reset        = 1'b1;
    bus.m_pc     = 30'd0;
    bus.exl      = 1'b0;
    bus.epc      = 30'd0;
    bus.stall_in = 1'b0;
    prev_redir   = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_flush", 64'(bus.flush), 64'd0);
    check("rst_redirect", 64'(bus.pc_redirect), 64'd0);
    check("rst_exc_we", 64'(bus.cp0_exc_we), 64'd0);
    check("rst_exl_clr", 64'(bus.cp0_exl_clr), 64'd0);
    check("rst_redirect_pc", 64'(bus.redirect_pc), 64'd0);
    check("rst_cp0_pc", 64'(bus.cp0_pc), 64'd0);
    check("rst_exc_count", 64'(bus.exc_count), 64'd0);
    check("rst_state", 64'(bus.state_dbg), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    step();

    // Synchronous exception.
    exp_q.push_back(ev_exc(5'd4, 30'h0C00, 1'b0));
    exp_q.push_back(ev_redir(30'h1060));
    issue(1'b0, 5'd4, 30'h0C00, 1'b0, 1'b0);
    bump_cnt();
    watch(nb, nf, nr, nx, ne);
    check("exc_busy_cycles", 64'(nb), 64'd4);
    check("exc_flush_cycles", 64'(nf), 64'd1);
    check("exc_we_cycles", 64'(nx), 64'd1);
    check("exc_redir_cycles", 64'(nr), 64'd1);
    check("exc_count_1", 64'(bus.exc_count), 64'(exp_cnt));

    // irq, exception and ERET together: the interrupt wins.
    exp_q.push_back(ev_exc(5'd0, 30'h0123, 1'b1));
    exp_q.push_back(ev_redir(30'h1060));
    issue(1'b1, 5'd10, 30'h0123, 1'b1, 1'b1);
    bump_cnt();
    watch(nb, nf, nr, nx, ne);
    check("prio_exl_clr_cycles", 64'(ne), 64'd0);
    check("prio_busy_cycles", 64'(nb), 64'd4);
    check("prio_exc_count", 64'(bus.exc_count), 64'(exp_cnt));

    // Interrupt pending during bubbles: nothing until a real instruction.
    bus.irq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check("bubble_busy", 64'(bus.busy), 64'd0);
    end
    exp_q.push_back(ev_exc(5'd0, 30'h0200, 1'b0));
    exp_q.push_back(ev_redir(30'h1060));
    issue(1'b1, 5'd0, 30'h0200, 1'b0, 1'b0);
    bump_cnt();
    watch(nb, nf, nr, nx, ne);
    check("bubble_irq_busy_cycles", 64'(nb), 64'd4);

    // Exception with EXL already set is ignored.
    bus.exl = 1'b1;
    bus.m_valid = 1'b1; bus.m_exccode = 5'd12; bus.m_pc = 30'h0333;
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      check("nest_busy", 64'(bus.busy), 64'd0);
    end
    idle_inputs();
    bus.exl = 1'b0;
    check("nest_exc_count", 64'(bus.exc_count), 64'(exp_cnt));

    // ERET with pc_redirect stretched by three stalled edges.
    bus.epc = 30'h0C01;
    exp_q.push_back(ev_eret());
    exp_q.push_back(ev_redir(30'h0C01));
    issue(1'b0, 5'd0, 30'h0444, 1'b0, 1'b1);
    fork
      watch(nb, nf, nr, nx, ne);
      begin
        @(posedge clk); #1; bus.stall_in = 1'b1;
        repeat (3) @(posedge clk);
        #1; bus.stall_in = 1'b0;
      end
    join
    check("eret_exl_clr_cycles", 64'(ne), 64'd1);
    check("eret_redir_cycles", 64'(nr), 64'd4);
    check("eret_busy_cycles", 64'(nb), 64'd7);
    check("eret_exc_we_cycles", 64'(nx), 64'd0);
    check("eret_redirect_pc", 64'(bus.redirect_pc), 64'h0C01);

    // Stall during ENTER does not stretch the strobe; only REDIR is held.
    exp_q.push_back(ev_exc(5'd6, 30'h0555, 1'b1));
    exp_q.push_back(ev_redir(30'h1060));
    issue(1'b0, 5'd6, 30'h0555, 1'b1, 1'b0);
    bump_cnt();
    bus.stall_in = 1'b1;
    fork
      watch(nb, nf, nr, nx, ne);
      begin
        repeat (2) @(posedge clk);
        #1; bus.stall_in = 1'b0;
      end
    join
    check("enter_stall_we_cycles", 64'(nx), 64'd1);
    check("enter_stall_flush_cycles", 64'(nf), 64'd1);
    check("enter_stall_redir_cycles", 64'(nr), 64'd2);
    check("enter_stall_busy_cycles", 64'(nb), 64'd5);

    // Saturation of the taken-exception counter.
    for (int i = 0; i < 70; i++) begin
      logic [4:0]  code;
      logic [29:0] pc;
      code = 5'(8 + (i % 4));
      pc   = 30'(32'h100 + i);
      exp_q.push_back(ev_exc(code, pc, 1'b0));
      exp_q.push_back(ev_redir(30'h1060));
      issue(1'b0, code, pc, 1'b0, 1'b0);
      bump_cnt();
      watch(nb, nf, nr, nx, ne);
    end
    check("sat_exc_count", 64'(bus.exc_count), 64'((1 << CNT_W) - 1));
    check("sat_model", 64'(bus.exc_count), 64'(exp_cnt));

    // Reset while pc_redirect is high.
    exp_q.push_back(ev_exc(5'd4, 30'h0666, 1'b0));
    exp_q.push_back(ev_redir(30'h1060));
    issue(1'b0, 5'd4, 30'h0666, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_redirect", 64'(bus.pc_redirect), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_redirect", 64'(bus.pc_redirect), 64'd0);
    check("async_rst_flush", 64'(bus.flush), 64'd0);
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_exc_count", 64'(bus.exc_count), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    nb = 0; nx = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.busy) nb++;
      if (bus.cp0_exc_we || bus.cp0_exl_clr || bus.pc_redirect) nx++;
    end
    check("post_rst_busy", 64'(nb), 64'd0);
    check("post_rst_no_strobe", 64'(nx), 64'd0);
    check("post_rst_state", 64'(bus.state_dbg), 64'd0);
    check("post_rst_exc_count", 64'(bus.exc_count), 64'd0);

    check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
